uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
- Parametrised successor to the two-command voice/UART keyword detector.
- Takes bytes from the UART receiver (po_data qualified by rx_down) and assembles them into fixed-length frames of CMD_LEN bytes.
- Matches each frame against a table of NUM_CMD commands and emits a one-cycle pulse per matched command.
- Drives NUM_CMD/2 latched outputs (even command sets, odd command clears) and counts unrecognised frames. An inter-byte gap timeout resynchronises partial frames.

Parameters:
- CMD_LEN, 2: bytes per command frame (1..8).
- NUM_CMD, 4: number of commands (even, 2..16).
- CMD_TABLE, "L0L1K0K1": NUM_CMD*CMD_LEN*8-bit flattened table.
  - Command i occupies bits [(i+1)*CMD_LEN*8-1 : i*CMD_LEN*8].
  - The first-received byte is the MSB of each entry.
  - Default values: cmd0="K1", cmd1="K0", cmd2="L1", cmd3="L0".
- GAP_TIMEOUT, 50000: clock cycles allowed between bytes of one frame before the partial frame is discarded (>=2).
- ERR_W, 8: width of the error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- po_data  in  8  received byte; valid only when rx_down=1.
- rx_down  in  1  one-cycle strobe: byte available.
- clr_err  in  1  synchronous clear of err_cnt.
- cmd_pulse  out  NUM_CMD  one-hot, one-cycle pulse; bit i = command i matched.
- cmd_valid  out  1  one-cycle pulse, coincident with any cmd_pulse bit.
- cmd_id  out  $clog2(NUM_CMD)  index of the last matched command; held between matches.
- frame_err  out  1  one-cycle pulse: complete frame matched no entry.
- err_cnt  out  ERR_W  saturating count of frame_err pulses.
- out_state  out  NUM_CMD/2  latched outputs; bit k set by cmd 2k, cleared by cmd 2k+1.

Behaviour:
- Reset (async, rst=1): all outputs 0; shift register, byte_cnt and gap_cnt cleared. Reset asserted mid-frame discards the partial frame; no pulses are emitted.
- Two states:
  - IDLE: byte_cnt=0.
  - COLLECT: 0 < byte_cnt < CMD_LEN.
- Byte accept: on rx_down, shift_reg <= {shift_reg, po_data} (left shift by 8), byte_cnt+1, gap_cnt <= 0.
- Frame completion: rx_down while byte_cnt == CMD_LEN-1.
  - Compare {shift_reg[(CMD_LEN-1)*8-1:0], po_data} against every table entry combinationally.
  - At that clock edge, register results and return to IDLE (byte_cnt <= 0). Frames are non-overlapping; there is no sliding-window match.
  - Match: cmd_pulse[i], cmd_valid and cmd_id <= i are visible the cycle after the completing rx_down (latency 1).
  - Duplicate entries: lowest index wins; exactly one bit of cmd_pulse is ever set.
  - No match: frame_err pulses with latency 1; err_cnt increments in the same cycle and saturates at all-ones.
- Gap timeout: gap_cnt increments every cycle in COLLECT without rx_down.
  - When gap_cnt == GAP_TIMEOUT-1 and rx_down=0: discard the frame, go to IDLE, clear gap_cnt. No frame_err is raised.
  - rx_down on the same cycle as expiry: the byte wins and is appended; the timeout is cancelled.
  - gap_cnt is held at 0 in IDLE. Width is $clog2(GAP_TIMEOUT).
- out_state: updated at the edge where cmd_pulse is high, so visible 2 cycles after the completing rx_down.
  - cmd 2k sets bit k; cmd 2k+1 clears bit k. Other bits are unchanged.
  - A repeated set or clear is idempotent.
- clr_err: sets err_cnt to 0 next cycle. If clr_err coincides with an increment, the clear wins (err_cnt=0).
- CMD_LEN=1: every rx_down completes a frame immediately; the gap timer is never active.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

Test Plan:
- Defaults; bytes 'K','1' three cycles apart -> cmd_pulse=4'b0001, cmd_valid=1, cmd_id=0 for one cycle, 1 cycle after the '1' strobe; out_state[0]=1 one cycle later; err_cnt=0.
- Then 'K','0' -> cmd_pulse=4'b0010, cmd_id=1, out_state[0]=0; send 'L','1' -> out_state=2'b10.
- Send 'K', idle 50000 cycles, then '1','K' -> no pulse after '1'; frame "1K" completes -> frame_err pulse, err_cnt=1, out_state unchanged.
- Send 'K', wait exactly 49999 cycles so rx_down for '1' coincides with expiry -> frame "K1" accepted, cmd_pulse[0] fires.
- Assert rst between 'K' and '1' -> all outputs 0; the following '1','K0' pair resyncs: '1','K' gives frame_err, then '0','?' frames continue from IDLE.
- 260 garbage frames "ZZ" with ERR_W=8 -> err_cnt saturates at 255; clr_err coinciding with a frame_err -> err_cnt=0.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
// Assembles UART bytes into fixed-length frames, matches them against a command
// table and drives one-cycle match pulses, set/clear latches and an error counter.
module uart_cmd_decoder #(
  parameter int CMD_LEN     = 2,
  parameter int NUM_CMD     = 4,
  parameter logic [NUM_CMD*CMD_LEN*8-1:0] CMD_TABLE = "L0L1K0K1",
  parameter int GAP_TIMEOUT = 50000,
  parameter int ERR_W       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 po_data,
  input  logic                       rx_down,
  input  logic                       clr_err,
  output logic [NUM_CMD-1:0]         cmd_pulse,
  output logic                       cmd_valid,
  output logic [$clog2(NUM_CMD)-1:0] cmd_id,
  output logic                       frame_err,
  output logic [ERR_W-1:0]           err_cnt,
  output logic [NUM_CMD/2-1:0]       out_state
);

  localparam int FW    = CMD_LEN * 8;
  localparam int ID_W  = $clog2(NUM_CMD);
  localparam int CNT_W = (CMD_LEN > 1) ? $clog2(CMD_LEN) : 1;
  localparam int GAP_W = $clog2(GAP_TIMEOUT);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   byte_cnt, byte_cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic [FW-1:0]      shift_reg, shift_reg_n;
  logic [FW-1:0]      frame;
  logic               complete;
  logic               hit;
  logic [ID_W-1:0]    hit_idx;

  // Frame as it would look with the current byte appended.
  always_comb begin
    frame      = shift_reg;
    frame      = frame << 8;
    frame[7:0] = po_data;
  end

  // Descending scan so the lowest matching index is the one kept.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_CMD - 1; i >= 0; i--) begin
      if (frame == CMD_TABLE[i*FW +: FW]) begin
        hit     = 1'b1;
        hit_idx = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_n     = state;
    byte_cnt_n  = byte_cnt;
    gap_cnt_n   = gap_cnt;
    shift_reg_n = shift_reg;
    complete    = 1'b0;
    if (rx_down) begin
      shift_reg_n = frame;
      gap_cnt_n   = '0;
      if (byte_cnt == CNT_W'(CMD_LEN - 1)) begin
        complete   = 1'b1;
        byte_cnt_n = '0;
        state_n    = IDLE;
      end else begin
        byte_cnt_n = byte_cnt + 1'b1;
        state_n    = COLLECT;
      end
    end else if (state == COLLECT) begin
      if (gap_cnt == GAP_W'(GAP_TIMEOUT - 1)) begin
        // Silent resync: a stalled partial frame is dropped without an error.
        state_n    = IDLE;
        byte_cnt_n = '0;
        gap_cnt_n  = '0;
      end else begin
        gap_cnt_n = gap_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_n;
      byte_cnt  <= byte_cnt_n;
      gap_cnt   <= gap_cnt_n;
      shift_reg <= shift_reg_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_pulse <= '0;
      cmd_valid <= 1'b0;
      cmd_id    <= '0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
      out_state <= '0;
    end else begin
      cmd_pulse <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      if (complete && hit) begin
        cmd_pulse[hit_idx] <= 1'b1;
        cmd_valid          <= 1'b1;
        cmd_id             <= hit_idx;
      end
      if (complete && !hit) frame_err <= 1'b1;
      if (clr_err) err_cnt <= '0;
      else if (complete && !hit && err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
      // Latches follow the registered pulse, one cycle behind the match.
      for (int k = 0; k < NUM_CMD / 2; k++) begin
        if (cmd_pulse[2*k])        out_state[k] <= 1'b1;
        else if (cmd_pulse[2*k+1]) out_state[k] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: default table, gap timeout, reset resync,
// error saturation/clear, plus a single-byte duplicate-entry instance.
module tb_uart_cmd_decoder;

  localparam int GAP = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] po_data;
  logic       rx_down;
  logic       clr_err;

  logic [3:0] cmd_pulse;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic       frame_err;
  logic [7:0] err_cnt;
  logic [1:0] out_state;

  logic [1:0] cmd_pulse1;
  logic       cmd_valid1;
  logic [0:0] cmd_id1;
  logic       frame_err1;
  logic [7:0] err_cnt1;
  logic [0:0] out_state1;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  // Clock / reset
  always #5 clk = ~clk;

  uart_cmd_decoder #(.GAP_TIMEOUT(GAP)) u_dut (
    .clk(clk), .rst(rst), .po_data(po_data), .rx_down(rx_down), .clr_err(clr_err),
    .cmd_pulse(cmd_pulse), .cmd_valid(cmd_valid), .cmd_id(cmd_id),
    .frame_err(frame_err), .err_cnt(err_cnt), .out_state(out_state)
  );

  uart_cmd_decoder #(.CMD_LEN(1), .NUM_CMD(2), .CMD_TABLE("AA"), .GAP_TIMEOUT(GAP)) u_dut1 (
    .clk(clk), .rst(rst), .po_data(po_data), .rx_down(rx_down), .clr_err(clr_err),
    .cmd_pulse(cmd_pulse1), .cmd_valid(cmd_valid1), .cmd_id(cmd_id1),
    .frame_err(frame_err1), .err_cnt(err_cnt1), .out_state(out_state1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks: always entered and left on a negedge.
  task automatic send_byte(input logic [7:0] b);
    po_data = b;
    rx_down = 1'b1;
    @(negedge clk);
    rx_down = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_cmd(input int idx);
    exp_q.push_back(4'b0001 << idx);
  endtask

  // Scoreboard: compare the pulse cycle against the front of the expected queue.
  task automatic check_cmd(input string tag, input logic [1:0] id);
    logic [3:0] exp_p;
    exp_p = exp_q.pop_front();
    check({tag, "_pulse"}, cmd_pulse, exp_p);
    check({tag, "_valid"}, cmd_valid, 1);
    check({tag, "_id"}, cmd_id, id);
    check({tag, "_ferr"}, frame_err, 0);
  endtask

  initial begin
    rst = 1'b1; po_data = 8'h00; rx_down = 1'b0; clr_err = 1'b0;
    idle(2);
    check("rst_pulse", cmd_pulse, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_errcnt", err_cnt, 0);
    check("rst_state", out_state, 0);
    rst = 1'b0;
    idle(1);

    // "K1" three cycles apart -> cmd0
    send_byte("K"); idle(2);
    check("k_partial_valid", cmd_valid, 0);
    expect_cmd(0);
    send_byte("1");
    check_cmd("k1", 2'd0);
    idle(1);
    check("k1_pulse_gone", cmd_pulse, 0);
    check("k1_state", out_state, 2'b01);
    check("k1_errcnt", err_cnt, 0);

    // "K0" -> cmd1 clears bit0; "L1" -> cmd2 sets bit1
    send_byte("K"); expect_cmd(1); send_byte("0");
    check_cmd("k0", 2'd1);
    idle(1);
    check("k0_state", out_state, 2'b00);
    send_byte("L"); expect_cmd(2); send_byte("1");
    check_cmd("l1", 2'd2);
    idle(1);
    check("l1_state", out_state, 2'b10);

    // Full timeout: partial "K" discarded, then "1K" is a bad frame
    send_byte("K"); idle(GAP);
    check("to_no_ferr", frame_err, 0);
    send_byte("1");
    check("to_1_valid", cmd_valid, 0);
    check("to_1_ferr", frame_err, 0);
    send_byte("K");
    check("1k_ferr", frame_err, 1);
    check("1k_pulse", cmd_pulse, 0);
    check("1k_errcnt", err_cnt, 1);
    check("1k_id_held", cmd_id, 2);
    idle(1);
    check("1k_ferr_gone", frame_err, 0);
    check("1k_state", out_state, 2'b10);

    // Byte lands on the expiry cycle: it wins
    send_byte("K"); idle(GAP - 1);
    expect_cmd(0);
    send_byte("1");
    check_cmd("edge", 2'd0);
    idle(1);
    check("edge_state", out_state, 2'b11);

    // Reset mid-frame
    send_byte("K");
    rst = 1'b1;
    #1;
    check("mid_rst_state", out_state, 0);
    check("mid_rst_id", cmd_id, 0);
    check("mid_rst_errcnt", err_cnt, 0);
    idle(1);
    rst = 1'b0;
    idle(1);
    send_byte("1"); send_byte("K");
    check("resync_ferr", frame_err, 1);
    check("resync_errcnt", err_cnt, 1);
    send_byte("0"); send_byte("?");
    check("resync2_ferr", frame_err, 1);
    check("resync2_errcnt", err_cnt, 2);

    // Saturation then clear
    for (int i = 0; i < 260; i++) begin
      send_byte("Z"); send_byte("Z");
    end
    check("sat_errcnt", err_cnt, 255);
    send_byte("Z");
    clr_err = 1'b1;
    send_byte("Z");
    clr_err = 1'b0;
    check("clr_ferr", frame_err, 1);
    check("clr_errcnt", err_cnt, 0);
    send_byte("Z"); send_byte("Z");
    check("post_clr_errcnt", err_cnt, 1);
    check("state_kept", out_state, 2'b00);

    // Single-byte instance with duplicated entries: lowest index wins
    send_byte("A");
    check("dup_pulse", cmd_pulse1, 2'b01);
    check("dup_valid", cmd_valid1, 1);
    check("dup_id", cmd_id1, 0);
    idle(1);
    check("dup_state", out_state1, 1);
    send_byte("B");
    check("len1_ferr", frame_err1, 1);
    check("len1_valid", cmd_valid1, 0);

    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
